// File: rtl/acumulador_booth_if.sv
// Product/sum interface between the Booth multiplier, the accumulator and its consumer.
// The accumulator is the slave. The multiplier and the consumer together form the master.
interface acumulador_booth_if #(
  parameter int NUM_BITS  = 3,
  parameter int ACC_BITS  = 8,
  parameter int NUM_TERMS = 4,
  localparam int CNT_BITS = $clog2(NUM_TERMS + 1)
);
  logic                    fin;
  logic [2*NUM_BITS-1:0]   resultado;
  logic                    limpiar;
  logic                    ack;
  logic [ACC_BITS-1:0]     suma;
  logic                    valido;
  logic                    ocupado;
  logic [CNT_BITS-1:0]     cuenta;
  logic                    desbordamiento;
  logic                    perdido;

  modport slave (
    input  fin, resultado, limpiar, ack,
    output suma, valido, ocupado, cuenta, desbordamiento, perdido
  );

  modport master (
    output fin, resultado, limpiar, ack,
    input  suma, valido, ocupado, cuenta, desbordamiento, perdido
  );
endinterface

// File: rtl/acumulador_booth.sv
// Saturating accumulator of NUM_TERMS signed Booth products, captured on rising edges of fin.
// The completed sum is handed to the consumer with a valid/ack handshake.
module acumulador_booth #(
  parameter int NUM_BITS  = 3,
  parameter int ACC_BITS  = 8,
  parameter int NUM_TERMS = 4,
  localparam int CNT_BITS = $clog2(NUM_TERMS + 1)
) (
  input logic                clk,
  input logic                rst_n,
  acumulador_booth_if.slave  bus
);

  typedef enum logic {ACUM = 1'b0, LISTO = 1'b1} estado_t;

  localparam logic [CNT_BITS-1:0] ULTIMO  = CNT_BITS'(NUM_TERMS - 1);
  localparam logic [ACC_BITS-1:0] SAT_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
  localparam logic [ACC_BITS-1:0] SAT_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};

  estado_t              estado_q, estado_d;
  logic                 fin_q;
  logic                 evento;
  logic [ACC_BITS-1:0]  suma_q, suma_d;
  logic [CNT_BITS-1:0]  cuenta_q, cuenta_d;
  logic                 desb_q, desb_d;
  logic                 perdido_q, perdido_d;

  logic [ACC_BITS:0]    prod_ext, suma_ext, total;
  logic [ACC_BITS-1:0]  suma_sat;
  logic                 satura;

  assign evento = bus.fin & ~fin_q;

  // One guard bit is enough: the top two bits of the sum differ exactly when it overflows.
  assign prod_ext = {{(ACC_BITS+1-2*NUM_BITS){bus.resultado[2*NUM_BITS-1]}}, bus.resultado};
  assign suma_ext = {suma_q[ACC_BITS-1], suma_q};
  assign total    = prod_ext + suma_ext;
  assign satura   = total[ACC_BITS] ^ total[ACC_BITS-1];

  always_comb begin
    if (!satura)             suma_sat = total[ACC_BITS-1:0];
    else if (total[ACC_BITS]) suma_sat = SAT_MIN;
    else                      suma_sat = SAT_MAX;
  end

  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves it unassigned and no latch is inferred.
    estado_d  = estado_q;
    suma_d    = suma_q;
    cuenta_d  = cuenta_q;
    desb_d    = desb_q;
    perdido_d = perdido_q;

    if (bus.limpiar) begin
      estado_d  = ACUM;
      suma_d    = '0;
      cuenta_d  = '0;
      desb_d    = 1'b0;
      perdido_d = 1'b0;
    end else begin
      case (estado_q)
        ACUM: begin
          if (evento) begin
            suma_d   = suma_sat;
            cuenta_d = cuenta_q + 1'b1;
            desb_d   = desb_q | satura;
            if (cuenta_q == ULTIMO) estado_d = LISTO;
          end
        end
        LISTO: begin
          // A product that arrives while the sum waits for ack is dropped, even if ack is also present.
          if (evento) perdido_d = 1'b1;
          if (bus.ack) begin
            estado_d = ACUM;
            suma_d   = '0;
            cuenta_d = '0;
            desb_d   = 1'b0;
          end
        end
        default: estado_d = ACUM;
      endcase
    end
  end

  // fin_q resets high, so a fin already high when reset is released does not count as a product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
      estado_q  <= ACUM;
      fin_q     <= 1'b1;
      suma_q    <= '0;
      cuenta_q  <= '0;
      desb_q    <= 1'b0;
      perdido_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      fin_q     <= bus.fin;
      suma_q    <= suma_d;
      cuenta_q  <= cuenta_d;
      desb_q    <= desb_d;
      perdido_q <= perdido_d;
    end
  end

  assign bus.suma           = suma_q;
  assign bus.cuenta         = cuenta_q;
  assign bus.desbordamiento = desb_q;
  assign bus.perdido        = perdido_q;
  assign bus.valido         = (estado_q == LISTO);
  assign bus.ocupado        = (estado_q == LISTO);

endmodule

// File: tb/tb_acumulador_booth.sv
// Directed bench for acumulador_booth: an 8-bit default instance, plus a 6-bit instance that
// receives the same stimulus and exercises saturation.
module tb_acumulador_booth;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  acumulador_booth_if                 bus_a ();
  acumulador_booth_if #(.ACC_BITS(6)) bus_b ();

  assign bus_b.fin       = bus_a.fin;
  assign bus_b.resultado = bus_a.resultado;
  assign bus_b.limpiar   = bus_a.limpiar;
  assign bus_b.ack       = bus_a.ack;

  acumulador_booth dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  acumulador_booth #(.ACC_BITS(6)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic producto(input logic [5:0] v);
    bus_a.resultado = v;
    bus_a.fin = 1'b1;
    step();
    bus_a.fin = 1'b0;
    step();
  endtask

  task automatic pulso_ack();
    bus_a.ack = 1'b1;
    step();
    bus_a.ack = 1'b0;
  endtask

  task automatic pulso_limpiar();
    bus_a.limpiar = 1'b1;
    step();
    bus_a.limpiar = 1'b0;
  endtask

  task automatic check_todo_cero(input string tag);
    check({tag, "_suma"},    32'(bus_a.suma), 32'h0);
    check({tag, "_cuenta"},  32'(bus_a.cuenta), 32'h0);
    check({tag, "_valido"},  32'(bus_a.valido), 32'h0);
    check({tag, "_ocupado"}, 32'(bus_a.ocupado), 32'h0);
    check({tag, "_desb"},    32'(bus_a.desbordamiento), 32'h0);
    check({tag, "_perdido"}, 32'(bus_a.perdido), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus_a.fin = 1'b0;
    bus_a.resultado = '0;
    bus_a.limpiar = 1'b0;
    bus_a.ack = 1'b0;

    // 1: reset values, then a long fin pulse counts once
    #3;
    check_todo_cero("reset");
    #9 rst_n = 1'b1;
    step();
    bus_a.resultado = 6'b000110;
    bus_a.fin = 1'b1;
    repeat (3) step();
    bus_a.fin = 1'b0;
    step();
    check("fin_largo_cuenta", 32'(bus_a.cuenta), 32'd1);
    check("fin_largo_suma",   32'(bus_a.suma), 32'd6);

    // 2: four products 6, -12, 16, 1 -> 11
    pulso_limpiar();
    check("limpiar_suma", 32'(bus_a.suma), 32'd0);
    producto(6'b000110);
    producto(6'b110100);
    check("parcial_suma", 32'(bus_a.suma), 32'hFA);
    producto(6'b010000);
    check("tercero_valido", 32'(bus_a.valido), 32'd0);
    bus_a.resultado = 6'b000001;
    bus_a.fin = 1'b1;
    step();
    check("final_valido",  32'(bus_a.valido), 32'd1);
    check("final_ocupado", 32'(bus_a.ocupado), 32'd1);
    check("final_suma",    32'(bus_a.suma), 32'd11);
    check("final_cuenta",  32'(bus_a.cuenta), 32'd4);
    check("final_desb",    32'(bus_a.desbordamiento), 32'd0);
    bus_a.fin = 1'b0;
    step();

    // 5: product while LISTO is lost
    producto(6'b000101);
    check("listo_suma",    32'(bus_a.suma), 32'd11);
    check("listo_cuenta",  32'(bus_a.cuenta), 32'd4);
    check("listo_perdido", 32'(bus_a.perdido), 32'd1);

    // 3: ack releases the sum; perdido survives ack
    pulso_ack();
    check("ack_valido",  32'(bus_a.valido), 32'd0);
    check("ack_ocupado", 32'(bus_a.ocupado), 32'd0);
    check("ack_suma",    32'(bus_a.suma), 32'd0);
    check("ack_cuenta",  32'(bus_a.cuenta), 32'd0);
    check("ack_perdido", 32'(bus_a.perdido), 32'd1);
    producto(6'b111101);
    check("neg_suma",   32'(bus_a.suma), 32'hFD);
    check("neg_cuenta", 32'(bus_a.cuenta), 32'd1);
    pulso_ack();
    check("ack_en_acum_suma", 32'(bus_a.suma), 32'hFD);
    pulso_limpiar();
    check("limpiar_perdido", 32'(bus_a.perdido), 32'd0);

    // 4: 6-bit accumulator saturates at 31
    producto(6'b010000);
    check("sat1_suma", 32'(bus_b.suma), 32'd16);
    check("sat1_desb", 32'(bus_b.desbordamiento), 32'd0);
    producto(6'b010000);
    check("sat2_suma", 32'(bus_b.suma), 32'd31);
    check("sat2_desb", 32'(bus_b.desbordamiento), 32'd1);
    producto(6'b010000);
    producto(6'b010000);
    check("sat4_suma",   32'(bus_b.suma), 32'd31);
    check("sat4_valido", 32'(bus_b.valido), 32'd1);
    check("sat4_desb",   32'(bus_b.desbordamiento), 32'd1);
    check("ancho_suma",  32'(bus_a.suma), 32'd64);
    pulso_ack();
    check("sat_ack_desb",   32'(bus_b.desbordamiento), 32'd0);
    check("sat_ack_valido", 32'(bus_b.valido), 32'd0);

    // Negative saturation at -32 on the 6-bit instance
    producto(6'b100000);
    producto(6'b111111);
    check("satneg_suma", 32'(bus_b.suma), 32'h20);
    check("satneg_desb", 32'(bus_b.desbordamiento), 32'd1);
    pulso_limpiar();

    // 6: asynchronous reset mid-accumulation
    producto(6'b000110);
    producto(6'b110100);
    check("pre_rst_cuenta", 32'(bus_a.cuenta), 32'd2);
    check("pre_rst_suma",   32'(bus_a.suma), 32'hFA);
    #3 rst_n = 1'b0;
    #1;
    check_todo_cero("rst_async");
    rst_n = 1'b1;
    step();
    producto(6'b000101);
    check("post_rst_suma", 32'(bus_a.suma), 32'd5);
    bus_a.resultado = 6'b000011;
    bus_a.fin = 1'b1;
    bus_a.limpiar = 1'b1;
    step();
    bus_a.limpiar = 1'b0;
    check_todo_cero("limpiar_evento");
    step();
    check("fin_alto_sin_evento", 32'(bus_a.cuenta), 32'd0);
    bus_a.fin = 1'b0;
    step();

    // fin already high when reset is released does not count
    rst_n = 1'b0;
    bus_a.fin = 1'b1;
    bus_a.resultado = 6'b000111;
    step();
    rst_n = 1'b1;
    repeat (2) step();
    check("fin_en_reset_cuenta", 32'(bus_a.cuenta), 32'd0);
    bus_a.fin = 1'b0;
    step();
    producto(6'b000111);
    check("tras_reset_suma", 32'(bus_a.suma), 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
